// File: rtl/alu_arbiter_riscv_pkg.sv
// Shared RISC-V ALU definitions: datapath widths, opcode encodings and the
// operand bundle handed from the arbiter to the ALU.
package alu_arbiter_riscv_pkg;

    localparam int XLEN  = 32;
    localparam int OP_W  = 5;

    typedef logic [OP_W-1:0] alu_op_t;

    // Arithmetic / logic / shift ops drive the result; comparison ops drive
    // the flag and leave the result at 0.
    localparam alu_op_t ALU_ADD  = 5'd0;
    localparam alu_op_t ALU_SUB  = 5'd1;
    localparam alu_op_t ALU_XOR  = 5'd2;
    localparam alu_op_t ALU_OR   = 5'd3;
    localparam alu_op_t ALU_AND  = 5'd4;
    localparam alu_op_t ALU_SLL  = 5'd5;
    localparam alu_op_t ALU_SRL  = 5'd6;
    localparam alu_op_t ALU_SRA  = 5'd7;
    localparam alu_op_t ALU_LTS  = 5'd8;
    localparam alu_op_t ALU_LTU  = 5'd9;
    localparam alu_op_t ALU_GES  = 5'd10;
    localparam alu_op_t ALU_GEU  = 5'd11;
    localparam alu_op_t ALU_EQ   = 5'd12;
    localparam alu_op_t ALU_NE   = 5'd13;

    // One registered operation: operands plus opcode.
    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        alu_op_t         op;
    } alu_req_t;

endpackage

// File: rtl/alu_riscv.sv
// Combinational RISC-V ALU. Undefined opcodes produce result 0 and flag 0.
module alu_riscv
    import alu_arbiter_riscv_pkg::*;
(
    input  logic [OP_W-1:0] op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result,
    output logic            flag
);

    // Decode the opcode into a result (arith/logic/shift) or a flag (compare).
    always_comb begin
        result = '0;
        flag   = 1'b0;
        case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_XOR: result = a ^ b;
            ALU_OR:  result = a | b;
            ALU_AND: result = a & b;
            ALU_SLL: result = a << b[4:0];
            ALU_SRL: result = a >> b[4:0];
            ALU_SRA: result = $unsigned($signed(a) >>> b[4:0]);
            ALU_LTS: flag   = ($signed(a) <  $signed(b));
            ALU_LTU: flag   = (a <  b);
            ALU_GES: flag   = ($signed(a) >= $signed(b));
            ALU_GEU: flag   = (a >= b);
            ALU_EQ:  flag   = (a == b);
            ALU_NE:  flag   = (a != b);
            default: begin
                result = '0;
                flag   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_arbiter_riscv.sv
// Two-port round-robin front end sharing one alu_riscv instance.
// Handshakes: a transfer happens on a clock edge where valid and ready are
// both 1. reqN_ready depends only on state, pointer and the valids, and is
// high for exactly one IDLE cycle per grant. rspN_valid stays high, with
// result/flag held, until rspN_ready is seen; result/flag read 0 otherwise.
// Each operation takes IDLE -> EXEC -> RESP, so an op accepted at edge N is
// visible as a response from edge N+2 and a new op can issue every 3 cycles.
module alu_arbiter_riscv
    import alu_arbiter_riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,

    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [XLEN-1:0] req0_a,
    input  logic [XLEN-1:0] req0_b,
    input  logic [OP_W-1:0] req0_op,
    output logic            rsp0_valid,
    input  logic            rsp0_ready,
    output logic [XLEN-1:0] rsp0_result,
    output logic            rsp0_flag,

    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [XLEN-1:0] req1_a,
    input  logic [XLEN-1:0] req1_b,
    input  logic [OP_W-1:0] req1_op,
    output logic            rsp1_valid,
    input  logic            rsp1_ready,
    output logic [XLEN-1:0] rsp1_result,
    output logic            rsp1_flag
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic            ptr_q;      // preferred port when both request
    logic            grant_q;    // port owning the in-flight operation
    alu_req_t        req_q;
    logic [XLEN-1:0] res_q;
    logic            flag_q;

    logic            grant_sel;
    logic            accept;
    logic            rsp_hs;
    logic [XLEN-1:0] alu_result;
    logic            alu_flag;

    // Round-robin pick: pointer breaks ties, a lone requester always wins.
    always_comb begin
        grant_sel = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_sel = ptr_q;
        end else if (req1_valid) begin
            grant_sel = 1'b1;
        end
    end

    assign accept = (state_q == IDLE) && !rst && (req0_valid || req1_valid);
    assign rsp_hs = (state_q == RESP) && (grant_q ? rsp1_ready : rsp0_ready);

    alu_riscv u_alu (
        .op     (req_q.op),
        .a      (req_q.a),
        .b      (req_q.b),
        .result (alu_result),
        .flag   (alu_flag)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand capture on grant, ALU capture in EXEC, pointer advance on handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= 1'b0;
            grant_q <= 1'b0;
            req_q   <= '0;
            res_q   <= '0;
            flag_q  <= 1'b0;
        end else begin
            if (accept) begin
                grant_q <= grant_sel;
                req_q   <= grant_sel ? alu_req_t'{a: req1_a, b: req1_b, op: req1_op}
                                     : alu_req_t'{a: req0_a, b: req0_b, op: req0_op};
            end
            if (state_q == EXEC) begin
                res_q  <= alu_result;
                flag_q <= alu_flag;
            end
            if (rsp_hs) begin
                ptr_q <= ~grant_q;
            end
        end
    end

    // Outputs: ready/valid gated by reset; response data zeroed when not valid.
    always_comb begin
        req0_ready  = accept && !grant_sel;
        req1_ready  = accept &&  grant_sel;
        rsp0_valid  = !rst && (state_q == RESP) && !grant_q;
        rsp1_valid  = !rst && (state_q == RESP) &&  grant_q;
        rsp0_result = rsp0_valid ? res_q  : '0;
        rsp0_flag   = rsp0_valid ? flag_q : 1'b0;
        rsp1_result = rsp1_valid ? res_q  : '0;
        rsp1_flag   = rsp1_valid ? flag_q : 1'b0;
    end

endmodule

// File: tb/tb_alu_arbiter_riscv.sv
// Directed bench for alu_arbiter_riscv: inputs change 2 time units after a
// rising edge, outputs are checked 1 unit later, well away from the next edge.
module tb_alu_arbiter_riscv;
    import alu_arbiter_riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_flag;
    logic [31:0] req0_a, req0_b, rsp0_result;
    logic [4:0]  req0_op;
    logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_flag;
    logic [31:0] req1_a, req1_b, rsp1_result;
    logic [4:0]  req1_op;

    int n_asserts = 0;
    int n_fails   = 0;

    always #5 clk = ~clk;

    alu_arbiter_riscv dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req0_op     (req0_op),
        .rsp0_valid  (rsp0_valid),
        .rsp0_ready  (rsp0_ready),
        .rsp0_result (rsp0_result),
        .rsp0_flag   (rsp0_flag),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .req1_op     (req1_op),
        .rsp1_valid  (rsp1_valid),
        .rsp1_ready  (rsp1_ready),
        .rsp1_result (rsp1_result),
        .rsp1_flag   (rsp1_flag)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive0(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
        req0_valid = v;
        req0_a     = a;
        req0_b     = b;
        req0_op    = op;
    endtask

    task automatic drive1(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
        req1_valid = v;
        req1_a     = a;
        req1_b     = b;
        req1_op    = op;
    endtask

    initial begin
        // Reset with both requests and both rsp_ready asserted: outputs stay quiet.
        rst = 1'b1;
        drive0(1'b1, 32'd1, 32'd2, ALU_ADD);
        drive1(1'b1, 32'd3, 32'd4, ALU_ADD);
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        tick();
        tick();
        settle();
        check("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
        check("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
        check("rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
        check("rst_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
        check("rst_rsp0_result", rsp0_result, 32'd0);
        check("rst_rsp1_flag", {31'd0, rsp1_flag}, 32'd0);

        // Idle with no requests.
        rst = 1'b0;
        drive0(1'b0, 32'd0, 32'd0, ALU_ADD);
        drive1(1'b0, 32'd0, 32'd0, ALU_ADD);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        settle();
        check("idle_req0_ready", {31'd0, req0_ready}, 32'd0);
        check("idle_req1_ready", {31'd0, req1_ready}, 32'd0);
        tick();

        // Port 0 alone: ADD 5 + 7 = 12, two-cycle latency.
        drive0(1'b1, 32'd5, 32'd7, ALU_ADD);
        settle();
        check("add_req0_ready", {31'd0, req0_ready}, 32'd1);
        check("add_req1_ready", {31'd0, req1_ready}, 32'd0);
        tick();
        drive0(1'b0, 32'd99, 32'd99, ALU_SUB);
        settle();
        check("add_exec_ready", {31'd0, req0_ready}, 32'd0);
        check("add_exec_valid", {31'd0, rsp0_valid}, 32'd0);
        check("add_exec_result", rsp0_result, 32'd0);
        tick();
        settle();
        check("add_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
        check("add_rsp0_result", rsp0_result, 32'd12);
        check("add_rsp0_flag", {31'd0, rsp0_flag}, 32'd0);
        check("add_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        settle();
        check("add_done_valid", {31'd0, rsp0_valid}, 32'd0);
        check("add_done_result", rsp0_result, 32'd0);

        // Port 1 LTS -1 < 1, response held for 5 cycles; port 0 locked out.
        drive1(1'b1, 32'hFFFF_FFFF, 32'd1, ALU_LTS);
        settle();
        check("lts_req1_ready", {31'd0, req1_ready}, 32'd1);
        tick();
        drive1(1'b0, 32'd0, 32'd0, ALU_ADD);
        drive0(1'b1, 32'd1, 32'd1, ALU_ADD);
        settle();
        check("lts_exec_req0_ready", {31'd0, req0_ready}, 32'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            settle();
            check("lts_hold_valid", {31'd0, rsp1_valid}, 32'd1);
            check("lts_hold_result", rsp1_result, 32'd0);
            check("lts_hold_flag", {31'd0, rsp1_flag}, 32'd1);
            check("lts_hold_req0_ready", {31'd0, req0_ready}, 32'd0);
            tick();
        end
        drive0(1'b0, 32'd0, 32'd0, ALU_ADD);
        rsp1_ready = 1'b1;
        settle();
        check("lts_hs_valid", {31'd0, rsp1_valid}, 32'd1);
        check("lts_hs_flag", {31'd0, rsp1_flag}, 32'd1);
        tick();
        rsp1_ready = 1'b0;
        settle();
        check("lts_done_valid", {31'd0, rsp1_valid}, 32'd0);
        check("lts_done_flag", {31'd0, rsp1_flag}, 32'd0);

        // Both request together with pointer at port 0: SUB first, then XOR.
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        drive0(1'b1, 32'd10, 32'd3, ALU_SUB);
        drive1(1'b1, 32'h0000_00F0, 32'h0000_00FF, ALU_XOR);
        settle();
        check("both_req0_ready", {31'd0, req0_ready}, 32'd1);
        check("both_req1_ready", {31'd0, req1_ready}, 32'd0);
        tick();
        drive0(1'b0, 32'd0, 32'd0, ALU_ADD);
        settle();
        check("both_exec_req1_ready", {31'd0, req1_ready}, 32'd0);
        tick();
        settle();
        check("sub_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
        check("sub_rsp0_result", rsp0_result, 32'd7);
        check("sub_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
        tick();
        settle();
        check("xor_req1_ready", {31'd0, req1_ready}, 32'd1);
        tick();
        drive1(1'b0, 32'd0, 32'd0, ALU_ADD);
        tick();
        settle();
        check("xor_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
        check("xor_rsp1_result", rsp1_result, 32'h0000_000F);
        check("xor_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
        tick();

        // Pointer back at port 0: SRA wins the tie, pending port 1 ADD follows.
        drive0(1'b1, 32'h8000_0000, 32'd4, ALU_SRA);
        drive1(1'b1, 32'd1, 32'd2, ALU_ADD);
        settle();
        check("ptr0_req0_ready", {31'd0, req0_ready}, 32'd1);
        check("ptr0_req1_ready", {31'd0, req1_ready}, 32'd0);
        tick();
        drive0(1'b0, 32'd0, 32'd0, ALU_ADD);
        tick();
        settle();
        check("sra_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
        check("sra_rsp0_result", rsp0_result, 32'hF800_0000);
        tick();
        settle();
        check("add2_req1_ready", {31'd0, req1_ready}, 32'd1);
        tick();
        drive1(1'b0, 32'd0, 32'd0, ALU_ADD);
        tick();
        settle();
        check("add2_rsp1_result", rsp1_result, 32'd3);
        tick();

        // Undefined opcode: result 0, flag 0.
        drive0(1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 5'b11111);
        settle();
        check("undef_req0_ready", {31'd0, req0_ready}, 32'd1);
        tick();
        drive0(1'b0, 32'd0, 32'd0, ALU_ADD);
        tick();
        settle();
        check("undef_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
        check("undef_rsp0_result", rsp0_result, 32'd0);
        check("undef_rsp0_flag", {31'd0, rsp0_flag}, 32'd0);
        tick();

        // Reset during EXEC (pointer was at port 1): no response, pointer back to 0.
        drive0(1'b1, 32'd3, 32'd4, ALU_ADD);
        settle();
        check("rstx_req0_ready", {31'd0, req0_ready}, 32'd1);
        tick();
        drive0(1'b0, 32'd0, 32'd0, ALU_ADD);
        rst = 1'b1;
        settle();
        check("rstx_exec_valid", {31'd0, rsp0_valid}, 32'd0);
        tick();
        rst = 1'b0;
        settle();
        check("rstx_after_valid0", {31'd0, rsp0_valid}, 32'd0);
        tick();
        settle();
        check("rstx_after_valid1", {31'd0, rsp0_valid}, 32'd0);
        drive0(1'b1, 32'd20, 32'd5, ALU_SUB);
        drive1(1'b1, 32'd7, 32'd7, ALU_ADD);
        settle();
        check("rstx_ptr_req0_ready", {31'd0, req0_ready}, 32'd1);
        check("rstx_ptr_req1_ready", {31'd0, req1_ready}, 32'd0);
        tick();
        drive0(1'b0, 32'd0, 32'd0, ALU_ADD);
        tick();
        settle();
        check("rstx_sub_result", rsp0_result, 32'd15);
        tick();
        settle();
        check("rstx_add_req1_ready", {31'd0, req1_ready}, 32'd1);
        tick();
        drive1(1'b0, 32'd0, 32'd0, ALU_ADD);
        tick();
        settle();
        check("rstx_add_result", rsp1_result, 32'd14);
        tick();

        // Reset during EXEC, then a lone port 1 request is taken on the first IDLE cycle.
        drive0(1'b1, 32'd1, 32'd1, ALU_ADD);
        settle();
        check("rsty_req0_ready", {31'd0, req0_ready}, 32'd1);
        tick();
        drive0(1'b0, 32'd0, 32'd0, ALU_ADD);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive1(1'b1, 32'd100, 32'd23, ALU_ADD);
        settle();
        check("rsty_req1_ready", {31'd0, req1_ready}, 32'd1);
        check("rsty_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
        tick();
        drive1(1'b0, 32'd0, 32'd0, ALU_ADD);
        tick();
        settle();
        check("rsty_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
        check("rsty_rsp1_result", rsp1_result, 32'd123);
        check("rsty_rsp0_valid2", {31'd0, rsp0_valid}, 32'd0);
        tick();
        settle();
        check("rsty_done_valid", {31'd0, rsp1_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
